seq_scan_ctrl: RTL and testbench



---
 rtl/seq_scan_pkg.sv | 22 ++
 rtl/seq_scan_core.sv | 48 ++++
 rtl/seq_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared encodings for the serial 1101 scan front end.
//   ctrl_state_t : controller states (IDLE, SHIFT, REPORT)
//   det_state_t  : detector states (D0..D3)
//   PATTERN      : the detected serial pattern, first bit in the MSB
package seq_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_scan_core.sv
// seq_scan_core: overlapping Mealy detector for the serial pattern 1101.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (forces D0)
//   en     : advance the detector with bit_in this cycle
//   clr    : force D0 on the next edge (wins over en)
//   bit_in : serial input bit
//   hit    : combinational, high when bit_in completes the pattern
//
// state | meaning
// D0    | initial, no useful prefix
// D1    | saw 1
// D2    | saw 11
// D3    | saw 110
module seq_scan_core
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic bit_in,
  output logic hit
);

  det_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= D0;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = D0;
    unique case (state)
      D0: state_nxt = bit_in ? D1 : D0;
      D1: state_nxt = bit_in ? D2 : D0;
      D2: state_nxt = bit_in ? D2 : D3;
      D3: state_nxt = bit_in ? D1 : D0;  // overlap: the final 1 restarts a prefix
      default: state_nxt = D0;
    endcase
  end

  assign hit = (state == D3) && (bit_in == PATTERN[0]);

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: word-in / count-out front end for a serial 1101 detector.
// Each accepted word is shifted MSB-first into the detector, one bit per
// clock; the number of matches in the word is returned on a valid/ready
// output and accumulated into a saturating running total. Detector state
// carries across words until flushed in IDLE.
// Optional feature: define SEQ_SCAN_HITMAP_EN to add out_hitmap, a per-bit
// map of which input bits completed a match.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input word handshake, in_data MSB shifted first
//   flush                : reset the detector to D0 (IDLE only)
//   clear_cnt            : zero total_hits (wins over a same-cycle increment)
//   out_valid/out_ready  : result handshake, out_hits = matches in the word
//   out_hitmap           : (SEQ_SCAN_HITMAP_EN) match-ending bit positions
//   total_hits           : saturating running total of matches
//   busy                 : high in SHIFT or REPORT
//
// state     | meaning
// ST_IDLE   | ready for a word, flush honoured here
// ST_SHIFT  | serialising the word into the detector
// ST_REPORT | presenting out_hits until out_ready
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         flush,
  input  logic                         clear_cnt,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DATA_W+1)-1:0]  out_hits,
`ifdef SEQ_SCAN_HITMAP_EN
  output logic [DATA_W-1:0]            out_hitmap,
`endif
  output logic [CNT_W-1:0]             total_hits,
  output logic                         busy
);

  localparam int HIT_W = $clog2(DATA_W+1);
  localparam logic [HIT_W-1:0] LAST_BIT = HIT_W'(DATA_W-1);

  ctrl_state_t state, state_nxt;

  logic [DATA_W-1:0] shreg;
  logic [HIT_W-1:0]  bit_cnt;
  logic [HIT_W-1:0]  word_hits;
  logic              accept;
  logic              det_en;
  logic              det_clr;
  logic              det_hit;

  seq_scan_core u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (det_en),
    .clr    (det_clr),
    .bit_in (shreg[DATA_W-1]),
    .hit    (det_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    det_en    = 1'b0;
    det_clr   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        // flush clears the detector on the accept edge, so a word
        // arriving with flush is scanned from D0
        det_clr  = flush;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy   = 1'b1;
        det_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_hits <= '0;
    end else if (accept) begin
      shreg     <= in_data;
      bit_cnt   <= '0;
      word_hits <= '0;
    end else if (det_en) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt + 1'b1;
      if (det_hit) begin
        word_hits <= word_hits + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      total_hits <= '0;
    end else if (det_en && det_hit && (total_hits != '1)) begin
      total_hits <= total_hits + 1'b1;
    end
  end

  assign out_hits = word_hits;

`ifdef SEQ_SCAN_HITMAP_EN
  localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] hitmap;

  // serial bit i lands on in_data bit DATA_W-1-i
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      hitmap <= '0;
    end else if (det_en && det_hit) begin
      hitmap <= hitmap | (MSB_ONE >> bit_cnt);
    end
  end

  assign out_hitmap = hitmap;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed self-checking bench for seq_scan_ctrl.
// Two instances share every input: a default one (CNT_W=16) and a narrow
// one (CNT_W=2) used to watch total_hits saturate.
module tb_seq_scan_ctrl;

  localparam int DATA_W = 8;
  localparam int HIT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              flush;
  logic              clear_cnt;
  logic              out_ready;
  logic [DATA_W-1:0] in_data;

  logic              in_ready, out_valid, busy;
  logic [HIT_W-1:0]  out_hits;
  logic [15:0]       total_hits;

  logic              s_in_ready, s_out_valid, s_busy;
  logic [HIT_W-1:0]  s_out_hits;
  logic [1:0]        s_total;

`ifdef SEQ_SCAN_HITMAP_EN
  logic [DATA_W-1:0] out_hitmap;
  logic [DATA_W-1:0] s_out_hitmap;
`endif

  seq_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .clear_cnt  (clear_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hits   (out_hits),
`ifdef SEQ_SCAN_HITMAP_EN
    .out_hitmap (out_hitmap),
`endif
    .total_hits (total_hits),
    .busy       (busy)
  );

  seq_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .clear_cnt  (clear_cnt),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_hits   (s_out_hits),
`ifdef SEQ_SCAN_HITMAP_EN
    .out_hitmap (s_out_hitmap),
`endif
    .total_hits (s_total),
    .busy       (s_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),   32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid),  32'd0);
    chk({tag, "_out_hits"},  32'(out_hits),   32'd0);
    chk({tag, "_total"},     32'(total_hits), 32'd0);
    chk({tag, "_busy"},      32'(busy),       32'd0);
  endtask

  // Send one word, check exact latency, the result, and the return to IDLE.
  task automatic run_word(input string tag, input logic [7:0] d, input logic fl,
                          input int stall, input int exp_hits, input int exp_total,
                          input int exp_stot, input logic [7:0] exp_map);
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk({tag, "_busy_shift"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_shift"}, 32'(in_ready), 32'd0);
    repeat (DATA_W-1) step();
    chk({tag, "_out_valid_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_hits"}, 32'(out_hits), 32'(exp_hits));
    chk({tag, "_total"}, 32'(total_hits), 32'(exp_total));
    chk({tag, "_sat_total"}, 32'(s_total), 32'(exp_stot));
`ifdef SEQ_SCAN_HITMAP_EN
    chk({tag, "_hitmap"}, 32'(out_hitmap), 32'(exp_map));
`else
    if (exp_map === 8'hxx) $display("unreachable");
`endif
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_hits"},  32'(out_hits),  32'(exp_hits));
      chk({tag, "_stall_ready"}, 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    clear_cnt = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;

    // 0xDB from D0: hits at serial bits 3 and 6; ends in D2. Repeats keep
    // giving 2 hits; the 2-bit total saturates at 3.
    run_word("db1", 8'hDB, 1'b0, 0, 2, 2, 2, 8'h12);
    run_word("db2", 8'hDB, 1'b0, 0, 2, 4, 3, 8'h12);
    run_word("db3", 8'hDB, 1'b0, 0, 2, 6, 3, 8'h12);

    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    chk("clear_total", 32'(total_hits), 32'd0);
    chk("clear_sat_total", 32'(s_total), 32'd0);

    // 0x03 (flush together with valid) then 0x40: the match straddles words
    run_word("x03a", 8'h03, 1'b1, 0, 0, 0, 0, 8'h00);
    run_word("x40a", 8'h40, 1'b0, 0, 1, 1, 1, 8'h40);

    // same words with a flush between them: no match
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_word("x03b", 8'h03, 1'b0, 0, 0, 1, 1, 8'h00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    run_word("x40b", 8'h40, 1'b0, 0, 0, 1, 1, 8'h00);

    // 0xFF leaves D2; 0x00 still gives nothing; hold REPORT for 5 cycles
    run_word("xff", 8'hFF, 1'b0, 0, 0, 1, 1, 8'h00);
    run_word("x00", 8'h00, 1'b0, 5, 0, 1, 1, 8'h00);

    // clear_cnt on the first hit cycle of 0xDB (edge t+4) beats the increment
    in_data  = 8'hDB;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    chk("clr_hit_total", 32'(total_hits), 32'd0);
    chk("clr_hit_sat_total", 32'(s_total), 32'd0);
    repeat (4) step();
    chk("clr_word_valid", 32'(out_valid), 32'd1);
    chk("clr_word_hits", 32'(out_hits), 32'd2);
    chk("clr_word_total", 32'(total_hits), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset on the 4th SHIFT cycle aborts the word
    in_data  = 8'hDB;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("abort");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_word("db_after", 8'hDB, 1'b0, 0, 2, 2, 2, 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
